// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition-code register, Cnd evaluation and the E->M pipeline register.
// Optional trap/status reporting (m_stat output) is enabled by defining EXE_TRAP_EN.
module execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         bubble,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  input  logic [3:0]   dstE,
  input  logic [3:0]   dstM,
`ifdef EXE_TRAP_EN
  output logic [1:0]   m_stat,
`endif
  output logic         m_valid,
  output logic [3:0]   m_icode,
  output logic         m_cnd,
  output logic [W-1:0] m_valE,
  output logic [W-1:0] m_valA,
  output logic [3:0]   m_dstE,
  output logic [3:0]   m_dstM,
  output logic [2:0]   cc
);

  localparam logic [3:0]   I_CMOV = 4'h2;
  localparam logic [3:0]   I_OPQ  = 4'h6;
  localparam logic [3:0]   I_JXX  = 4'h7;
  localparam logic [3:0]   I_NOP  = 4'h1;
  localparam logic [W-1:0] EIGHT  = {{(W-4){1'b0}}, 4'd8};

  function automatic logic add_ovf(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                   input logic signed [W-1:0] r);
    return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  // b - a overflows when the operands differ in sign and the result leaves b's sign.
  function automatic logic sub_ovf(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                   input logic signed [W-1:0] r);
    return ((a < 0) != (b < 0)) && ((r < 0) != (b < 0));
  endfunction

  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] flags);
    logic zf, sf, of;
    {zf, sf, of} = flags;
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return (sf ^ of) | zf;
      4'h2:    return sf ^ of;
      4'h3:    return zf;
      4'h4:    return ~zf;
      4'h5:    return ~(sf ^ of);
      4'h6:    return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

  logic [W-1:0] sum_p0, diff_p0, alu_p0;
  logic         op_ok_p0, of_p0, cnd_p0, load_p0, cc_upd_p0;
  logic [2:0]   cc_next_p0;
  logic [3:0]   dst_e_p0, dst_m_p0;

  always_comb begin
    sum_p0   = valB + valA;
    diff_p0  = valB - valA;
    alu_p0   = '0;
    op_ok_p0 = 1'b0;
    of_p0    = 1'b0;
    case (icode)
      4'h2:       alu_p0 = valA;
      4'h3:       alu_p0 = valC;
      4'h4, 4'h5: alu_p0 = valB + valC;
      4'h6: begin
        case (ifun)
          4'h0: begin alu_p0 = sum_p0;  op_ok_p0 = 1'b1; of_p0 = add_ovf(valA, valB, sum_p0); end
          4'h1: begin alu_p0 = diff_p0; op_ok_p0 = 1'b1; of_p0 = sub_ovf(valA, valB, diff_p0); end
          4'h2: begin alu_p0 = valB & valA; op_ok_p0 = 1'b1; end
          4'h3: begin alu_p0 = valB ^ valA; op_ok_p0 = 1'b1; end
          default: ;
        endcase
      end
      4'h8, 4'hA: alu_p0 = valB - EIGHT;
      4'h9, 4'hB: alu_p0 = valB + EIGHT;
      default: ;
    endcase
  end

`ifdef EXE_TRAP_EN
  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_INS = 2'd2;

  logic [1:0] stat_p0;
  logic       trapped;

  always_comb begin
    stat_p0 = S_AOK;
    if ((icode > 4'hB) || ((icode == I_OPQ) && !op_ok_p0)) stat_p0 = S_INS;
    else if (icode == 4'h0)                                stat_p0 = S_HLT;
  end
`endif

  always_comb begin
    load_p0    = in_valid && !stall && !bubble;
    cc_next_p0 = {alu_p0 == '0, alu_p0[W-1], of_p0};
    cnd_p0     = ((icode == I_CMOV) || (icode == I_JXX)) ? cond_eval(ifun, cc) : 1'b0;
    dst_e_p0   = ((icode == I_CMOV) && !cnd_p0) ? RNONE : dstE;
    dst_m_p0   = dstM;
`ifdef EXE_TRAP_EN
    cc_upd_p0  = load_p0 && (icode == I_OPQ) && op_ok_p0 && !trapped;
    if (stat_p0 == S_INS) begin
      dst_e_p0 = RNONE;
      dst_m_p0 = RNONE;
    end
`else
    cc_upd_p0  = load_p0 && (icode == I_OPQ) && op_ok_p0;
`endif
  end

  // ---- E -> M pipeline register and CC register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_icode <= I_NOP;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= RNONE;
      m_dstM  <= RNONE;
      cc      <= 3'b100;
    end else if (!stall) begin
      if (load_p0) begin
        m_valid <= 1'b1;
        m_icode <= icode;
        m_cnd   <= cnd_p0;
        m_valE  <= alu_p0;
        m_valA  <= valA;
        m_dstE  <= dst_e_p0;
        m_dstM  <= dst_m_p0;
      end else begin
        m_valid <= 1'b0;
        m_icode <= I_NOP;
        m_cnd   <= 1'b0;
        m_valE  <= '0;
        m_valA  <= '0;
        m_dstE  <= RNONE;
        m_dstM  <= RNONE;
      end
      if (cc_upd_p0) cc <= cc_next_p0;
    end
  end

`ifdef EXE_TRAP_EN
  // Once a halt or illegal instruction has been registered, CC stays frozen until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stat  <= S_AOK;
      trapped <= 1'b0;
    end else if (!stall) begin
      m_stat <= load_p0 ? stat_p0 : S_AOK;
      if (load_p0 && (stat_p0 != S_AOK)) trapped <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage (default build, EXE_TRAP_EN undefined).
module tb_execute_stage;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, stall, bubble;
  logic [3:0]   icode, ifun, dstE, dstM;
  logic [W-1:0] valA, valB, valC;
  logic         m_valid, m_cnd;
  logic [3:0]   m_icode, m_dstE, m_dstM;
  logic [W-1:0] m_valE, m_valA;
  logic [2:0]   cc;

  int vectors = 0;
  int miscompares = 0;

  execute_stage #(.W(W), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .bubble(bubble),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE(dstE), .dstM(dstM),
    .m_valid(m_valid), .m_icode(m_icode), .m_cnd(m_cnd), .m_valE(m_valE), .m_valA(m_valA),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .cc(cc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c, input logic [3:0] de,
                       input logic [3:0] dm);
    in_valid = 1'b1; icode = ic; ifun = fn; valA = a; valB = b; valC = c; dstE = de; dstM = dm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; bubble = 1'b0;
    icode = 4'h0; ifun = 4'h0; valA = '0; valB = '0; valC = '0; dstE = 4'h0; dstM = 4'h0;
    step(); step();
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", m_valid); end
    vectors++; if (m_icode !== 4'h1) begin miscompares++; $display("FAIL reset_icode got %h exp 1", m_icode); end
    vectors++; if (m_dstE !== 4'hF) begin miscompares++; $display("FAIL reset_dstE got %h exp F", m_dstE); end
    vectors++; if (cc !== 3'b100) begin miscompares++; $display("FAIL reset_cc got %b exp 100", cc); end
    rst_n = 1'b1;
    step(); step();
    vectors++; if (m_valid !== 1'b0 || m_icode !== 4'h1 || m_dstM !== 4'hF || m_valE !== '0)
      begin miscompares++; $display("FAIL idle_after_reset got valid=%b icode=%h dstM=%h valE=%h exp 0/1/F/0", m_valid, m_icode, m_dstM, m_valE); end
    vectors++; if (cc !== 3'b100) begin miscompares++; $display("FAIL idle_cc got %b exp 100", cc); end
  endtask

  task automatic test_opq_sub();
    drive(4'h6, 4'h1, 64'd5, 64'd5, '0, 4'h2, 4'hF);
    step();
    vectors++; if (m_valE !== 64'h0) begin miscompares++; $display("FAIL sub_zero_valE got %h exp 0", m_valE); end
    vectors++; if (cc !== 3'b100) begin miscompares++; $display("FAIL sub_zero_cc got %b exp 100", cc); end
    vectors++; if (m_valid !== 1'b1 || m_icode !== 4'h6 || m_dstE !== 4'h2)
      begin miscompares++; $display("FAIL sub_zero_ctl got valid=%b icode=%h dstE=%h exp 1/6/2", m_valid, m_icode, m_dstE); end
    drive(4'h6, 4'h1, 64'd1, 64'd0, '0, 4'h2, 4'hF);
    step();
    vectors++; if (m_valE !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL sub_neg_valE got %h exp FFFFFFFFFFFFFFFF", m_valE); end
    vectors++; if (cc !== 3'b010) begin miscompares++; $display("FAIL sub_neg_cc got %b exp 010", cc); end
  endtask

  task automatic test_overflow();
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'h1, 4'hF);
    step();
    vectors++; if (m_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin miscompares++; $display("FAIL add_ovf_valE got %h exp FFFFFFFFFFFFFFFE", m_valE); end
    vectors++; if (cc !== 3'b011) begin miscompares++; $display("FAIL add_ovf_cc got %b exp 011", cc); end
    drive(4'h7, 4'h2, '0, '0, 64'h40, 4'hF, 4'hF);
    step();
    vectors++; if (m_cnd !== 1'b0) begin miscompares++; $display("FAIL jl_after_ovf got %b exp 0", m_cnd); end
    vectors++; if (cc !== 3'b011) begin miscompares++; $display("FAIL jl_cc_hold got %b exp 011", cc); end
  endtask

  task automatic test_cmov();
    drive(4'h6, 4'h1, 64'd1, 64'd0, '0, 4'hF, 4'hF);
    step();
    vectors++; if (cc !== 3'b010) begin miscompares++; $display("FAIL cmov_setup_cc got %b exp 010", cc); end
    drive(4'h2, 4'h1, 64'd42, '0, '0, 4'h3, 4'hF);
    step();
    vectors++; if (m_cnd !== 1'b1 || m_dstE !== 4'h3 || m_valE !== 64'd42)
      begin miscompares++; $display("FAIL cmovle_taken got cnd=%b dstE=%h valE=%h exp 1/3/2a", m_cnd, m_dstE, m_valE); end
    drive(4'h6, 4'h1, 64'd1, 64'd2, '0, 4'hF, 4'hF);
    step();
    vectors++; if (cc !== 3'b000) begin miscompares++; $display("FAIL cmov_setup2_cc got %b exp 000", cc); end
    drive(4'h2, 4'h1, 64'd42, '0, '0, 4'h3, 4'hF);
    step();
    vectors++; if (m_cnd !== 1'b0 || m_dstE !== 4'hF)
      begin miscompares++; $display("FAIL cmovle_not_taken got cnd=%b dstE=%h exp 0/F", m_cnd, m_dstE); end
  endtask

  task automatic test_stack();
    drive(4'hA, 4'h0, 64'h77, 64'h100, '0, 4'h4, 4'hF);
    step();
    vectors++; if (m_valE !== 64'hF8 || m_valA !== 64'h77)
      begin miscompares++; $display("FAIL pushq got valE=%h valA=%h exp f8/77", m_valE, m_valA); end
    drive(4'hB, 4'h0, 64'h100, 64'h100, '0, 4'h4, 4'h5);
    step();
    vectors++; if (m_valE !== 64'h108 || m_dstM !== 4'h5)
      begin miscompares++; $display("FAIL popq got valE=%h dstM=%h exp 108/5", m_valE, m_dstM); end
    drive(4'h5, 4'h0, '0, 64'h20, 64'h8, 4'hF, 4'h6);
    step();
    vectors++; if (m_valE !== 64'h28 || m_icode !== 4'h5)
      begin miscompares++; $display("FAIL mrmovq got valE=%h icode=%h exp 28/5", m_valE, m_icode); end
    vectors++; if (m_cnd !== 1'b0 || cc !== 3'b000)
      begin miscompares++; $display("FAIL mrmovq_cnd_cc got cnd=%b cc=%b exp 0/000", m_cnd, cc); end
  endtask

  task automatic test_control();
    drive(4'h6, 4'h0, '0, '0, '0, 4'h1, 4'hF);
    stall = 1'b1;
    step();
    vectors++; if (m_valE !== 64'h28 || m_icode !== 4'h5 || m_valid !== 1'b1 || cc !== 3'b000)
      begin miscompares++; $display("FAIL stall_hold got valE=%h icode=%h valid=%b cc=%b exp 28/5/1/000", m_valE, m_icode, m_valid, cc); end
    stall = 1'b0; bubble = 1'b1;
    step();
    vectors++; if (m_valid !== 1'b0 || m_icode !== 4'h1 || m_valE !== '0 || m_dstE !== 4'hF || cc !== 3'b000)
      begin miscompares++; $display("FAIL bubble got valid=%b icode=%h valE=%h dstE=%h cc=%b exp 0/1/0/F/000", m_valid, m_icode, m_valE, m_dstE, cc); end
    bubble = 1'b0;
    drive(4'h3, 4'h0, '0, '0, 64'h55, 4'h2, 4'hF);
    step();
    vectors++; if (m_valE !== 64'h55 || m_valid !== 1'b1)
      begin miscompares++; $display("FAIL irmovq got valE=%h valid=%b exp 55/1", m_valE, m_valid); end
    drive(4'h6, 4'h0, '0, '0, '0, 4'h1, 4'hF);
    stall = 1'b1; bubble = 1'b1;
    step();
    vectors++; if (m_valE !== 64'h55 || m_valid !== 1'b1 || m_icode !== 4'h3 || cc !== 3'b000)
      begin miscompares++; $display("FAIL stall_bubble_hold got valE=%h valid=%b icode=%h cc=%b exp 55/1/3/000", m_valE, m_valid, m_icode, cc); end
    stall = 1'b0; bubble = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if (m_valid !== 1'b0 || m_valE !== '0 || m_icode !== 4'h1 || cc !== 3'b100)
      begin miscompares++; $display("FAIL async_reset got valid=%b valE=%h icode=%h cc=%b exp 0/0/1/100", m_valid, m_valE, m_icode, cc); end
    rst_n = 1'b1;
    drive(4'h7, 4'h3, '0, '0, 64'h80, 4'hF, 4'hF);
    step();
    vectors++; if (m_cnd !== 1'b1 || m_icode !== 4'h7)
      begin miscompares++; $display("FAIL je_after_reset got cnd=%b icode=%h exp 1/7", m_cnd, m_icode); end
    in_valid = 1'b0;
    step();
    vectors++; if (m_valid !== 1'b0 || m_cnd !== 1'b0)
      begin miscompares++; $display("FAIL invalid_is_bubble got valid=%b cnd=%b exp 0/0", m_valid, m_cnd); end
  endtask

  initial begin
    test_reset();
    test_opq_sub();
    test_overflow();
    test_cmov();
    test_stack();
    test_control();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
